// File: rtl/led_matrix_pkg.sv
// Shared geometry, colour codes and scan-state encoding for the 5x5 LED matrix scanner.
package led_matrix_pkg;
    localparam int ROWS       = 5;
    localparam int COLS       = 5;
    localparam int LED_BITS   = 2;
    localparam int NUM_LEDS   = ROWS * COLS;
    localparam int ROW_BITS   = COLS * LED_BITS;
    localparam int FRAME_BITS = NUM_LEDS * LED_BITS;

    localparam logic [1:0] CLR_OFF   = 2'b00;
    localparam logic [1:0] CLR_RED   = 2'b01;
    localparam logic [1:0] CLR_GREEN = 2'b10;
    localparam logic [1:0] CLR_BOTH  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Selects the frame bits belonging to one row.
    function automatic logic [FRAME_BITS-1:0] row_mask(input logic [2:0] row);
        logic [FRAME_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            m[i] = ((i / ROW_BITS) == int'(row));
        end
        return m;
    endfunction
endpackage

// File: rtl/led_row_timer.sv
// Down-counting phase timer shared by the blank and drive phases; done at terminal count zero.
module led_row_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic             done
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/led_scan_ctrl.sv
// Double-buffered 5x5 LED row scanner with frame-boundary buffer swap.
// Optional LED_SCAN_BRIGHT_EN adds a bright[1:0] input that shortens the lit part of each row.
module led_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_addr,
    input  logic [1:0]  wr_data,
    input  logic        commit,
    output logic        swap_done,
    output logic        wr_err,
`ifdef LED_SCAN_BRIGHT_EN
    input  logic [1:0]  bright,
`endif
    output logic [49:0] Outbus,
    output logic [4:0]  Gnd
);
    // state | meaning
    // IDLE  | scan stopped, all rows off; pending swap is applied here at once
    // BLANK | all rows off for BLANK_CYCLES before the next row is selected
    // DRIVE | row row_q selected for DWELL_CYCLES, front-buffer LEDs driven

    localparam logic [15:0] DWELL_LD = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] BLANK_LD = 16'(BLANK_CYCLES - 1);

    scan_state_e           state_q, state_d;
    logic [2:0]            row_q, row_d;
    logic [FRAME_BITS-1:0] front_q, front_d;
    logic [FRAME_BITS-1:0] back_q, back_d;
    logic                  pending_q, pending_d;
    logic                  swap_done_q, swap_done_d;
    logic                  wr_err_q, wr_err_d;
    logic [4:0]            gnd_q, gnd_d;
    logic [FRAME_BITS-1:0] outbus_q, outbus_d;

    logic        tmr_load, tmr_count, tmr_done;
    logic [15:0] tmr_val;
    logic        wr_fire, swap, drive_on;

    led_row_timer #(.WIDTH(16)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_count = 1'b0;
        if (!enable) begin
            state_d  = IDLE;
            row_d    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LD;
                end
                BLANK: begin
                    if (tmr_done) begin
                        state_d  = DRIVE;
                        tmr_load = 1'b1;
                        tmr_val  = DWELL_LD;
                    end else begin
                        tmr_count = 1'b1;
                    end
                end
                DRIVE: begin
                    if (tmr_done) begin
                        state_d  = BLANK;
                        tmr_load = 1'b1;
                        tmr_val  = BLANK_LD;
                        row_d    = (row_q == 3'(ROWS - 1)) ? 3'd0 : row_q + 3'd1;
                    end else begin
                        tmr_count = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Swap only at a frame boundary so a frame is never shown half old, half new.
    assign swap = pending_q &&
                  ((state_q == IDLE) ||
                   ((state_q == DRIVE) && (row_q == 3'(ROWS - 1)) && tmr_done));

    assign wr_ready = ~pending_q;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        back_d      = back_q;
        front_d     = swap ? back_q : front_q;
        pending_d   = pending_q;
        swap_done_d = swap;
        wr_err_d    = wr_fire && (wr_addr > 5'(NUM_LEDS - 1));
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_fire && (wr_addr == 5'(i))) begin
                back_d[i*LED_BITS +: LED_BITS] = wr_data;
            end
        end
        if (swap) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end
    end

`ifdef LED_SCAN_BRIGHT_EN
    logic [15:0] lit_cnt_q, lit_cnt_d;
    logic [31:0] lit_lim;

    always_comb begin
        lit_cnt_d = '0;
        if (enable && (state_q == DRIVE) && !tmr_done) begin
            lit_cnt_d = lit_cnt_q + 16'd1;
        end
        lit_lim  = 32'(((int'(bright) + 1) * DWELL_CYCLES) / 4);
        drive_on = ({16'd0, lit_cnt_q} < lit_lim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lit_cnt_q <= '0;
        end else begin
            lit_cnt_q <= lit_cnt_d;
        end
    end
`else
    assign drive_on = 1'b1;
`endif

    // Gating with enable blanks the matrix on the same edge the scan drops to IDLE.
    always_comb begin
        gnd_d    = 5'b11111;
        outbus_d = '0;
        if (enable && (state_q == DRIVE)) begin
            gnd_d = ~(5'(1) << row_q);
            if (drive_on) begin
                outbus_d = front_q & row_mask(row_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            front_q     <= '0;
            back_q      <= '0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
            gnd_q       <= 5'b11111;
            outbus_q    <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            front_q     <= front_d;
            back_q      <= back_d;
            pending_q   <= pending_d;
            swap_done_q <= swap_done_d;
            wr_err_q    <= wr_err_d;
            gnd_q       <= gnd_d;
            outbus_q    <= outbus_d;
        end
    end

    assign swap_done = swap_done_q;
    assign wr_err    = wr_err_q;
    assign Gnd       = gnd_q;
    assign Outbus    = outbus_q;
endmodule
